// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: builds the 44-word expanded key one word per clock.
// key_out holds round r at [1407-128*r -: 128]; finish marks a complete schedule.
module key_expansion_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[a];
endmodule

module key_expansion (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [127:0]    key_in,
  output logic [1407:0]   key_out,
  output logic            busy,
  output logic            finish
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t          state_q;
  logic [5:0]      i_q;
  logic [7:0]      rcon_q;
  logic [31:0]     words [64];
  logic [3:0][7:0] rot_w, sub_w;
  logic [31:0]     temp, w_new;
  logic [7:0]      rcon_nxt;

  // Word view of key_out; indices past w43 read 0 so i_q-1 never reaches undefined data.
  for (genvar g = 0; g < 64; g++) begin : g_words
    if (g < 44) begin : g_live
      assign words[g] = key_out[1407-32*g -: 32];
    end else begin : g_pad
      assign words[g] = '0;
    end
  end

  assign rot_w = {words[i_q-6'd1][23:0], words[i_q-6'd1][31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    key_expansion_sbox u_sbox (.a(rot_w[b]), .y(sub_w[b]));
  end

  assign rcon_nxt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    temp = words[i_q-6'd1];
    if (i_q[1:0] == 2'b00) temp = sub_w ^ {rcon_q, 24'h0};
    w_new = words[i_q-6'd4] ^ temp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      key_out <= '0;
      busy    <= 1'b0;
      finish  <= 1'b0;
      i_q     <= '0;
      rcon_q  <= 8'h01;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            key_out <= {key_in, 1280'b0};
            i_q     <= 6'd4;
            rcon_q  <= 8'h01;
            busy    <= 1'b1;
            finish  <= 1'b0;
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          for (int g = 4; g < 44; g++)
            if (i_q == 6'(g)) key_out[1407-32*g -: 32] <= w_new;
          i_q <= i_q + 6'd1;
          if (i_q[1:0] == 2'b00) rcon_q <= rcon_nxt;
          if (i_q == 6'd43) begin
            state_q <= DONE;
            busy    <= 1'b0;
            finish  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
